instr_fetch_unit: RTL

//   Fetch stage of the MIPS core, directly upstream of the Control decoder. Holds the PC,

---
 rtl/instr_fetch_unit_pkg.sv | 25 ++
 rtl/instr_fetch_unit_next_pc_logic.sv | 22 ++
 rtl/instr_fetch_unit.sv | 100 ++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the fetch stage: FSM state encoding, word width
// and the MIPS opcode constants seen by Control.
package instr_fetch_unit_pkg;

  localparam int WORD = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    FETCH  = 2'b01,
    DECODE = 2'b10
  } fetch_state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  // j keeps the 256 MB region of the following instruction
  function automatic logic [WORD-1:0] jump_target(input logic [WORD-1:0] pc_plus4,
                                                  input logic [25:0]     index);
    return {pc_plus4[31:28], index, 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_next_pc_logic.sv
// Combinational next-PC selection: jump, taken beq, or fall-through.
module next_pc_logic
  import instr_fetch_unit_pkg::*;
(
  input  logic [WORD-1:0] PCPlus4,
  input  logic [25:0]     instr_index,
  input  logic [WORD-1:0] BranchOffset,
  input  logic            Branch,
  input  logic            Zero,
  input  logic            Jump,
  output logic [WORD-1:0] next_pc
);

  always_comb begin
    next_pc = PCPlus4;
    if (Jump)
      next_pc = jump_target(PCPlus4, instr_index);
    else if (Branch && Zero)
      next_pc = PCPlus4 + (BranchOffset << 2);
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC, fetches one word per req/ack handshake and
// presents it to decode until it retires; no speculation, no delay slot.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [WORD-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            Branch,
  input  logic            Zero,
  input  logic            Jump,
  input  logic [WORD-1:0] BranchOffset,
  input  logic            Stall,
  output logic            imem_req,
  output logic [WORD-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [WORD-1:0] imem_rdata,
  output logic [WORD-1:0] Instr,
  output logic [5:0]      Op,
  output logic [WORD-1:0] PC,
  output logic [WORD-1:0] PCPlus4,
  output logic            InstrValid
);

  fetch_state_t    state, state_next;
  logic [WORD-1:0] next_pc;

  next_pc_logic u_next_pc (
    .PCPlus4      (PCPlus4),
    .instr_index  (Instr[25:0]),
    .BranchOffset (BranchOffset),
    .Branch       (Branch),
    .Zero         (Zero),
    .Jump         (Jump),
    .next_pc      (next_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = FETCH;
      FETCH:   if (imem_ack) state_next = DECODE;
      DECODE:  if (!Stall)   state_next = FETCH;
      default: state_next = IDLE;
    endcase
  end

  // Datapath registers follow the state transitions; an ack outside FETCH
  // and a stall outside DECODE fall through the case and change nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_req   <= 1'b0;
      imem_addr  <= RESET_PC;
      Instr      <= '0;
      PC         <= '0;
      PCPlus4    <= '0;
      InstrValid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          imem_req  <= 1'b1;
          imem_addr <= RESET_PC;
        end
        FETCH: begin
          if (imem_ack) begin
            Instr      <= imem_rdata;
            PC         <= imem_addr;
            PCPlus4    <= imem_addr + 32'd4;
            InstrValid <= 1'b1;
            imem_req   <= 1'b0;
          end
        end
        DECODE: begin
          if (!Stall) begin
            imem_addr  <= next_pc;
            imem_req   <= 1'b1;
            InstrValid <= 1'b0;
          end
        end
        default: begin
          imem_req   <= 1'b0;
          InstrValid <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    Op = Instr[31:26];
  end

endmodule
